// File: rtl/seq_div_16x8.sv
// rtl/seq_div_16x8.sv - sequential 16-bit by 8-bit unsigned restoring divider
//
// Purpose:
//   Divides a 16-bit unsigned dividend by an 8-bit unsigned divisor, one
//   quotient bit per clock, behind valid/ready handshakes on both sides.
//   Divide-by-zero skips the iteration loop and returns Q=16'hFFFF, R=A[7:0]
//   with dz=1.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   divider can accept operands (only in IDLE)
//   A          dividend, unsigned, 16 bits
//   B          divisor, unsigned, 8 bits
//   out_valid  result valid (only in DONE)
//   out_ready  consumer accepts result
//   Q          quotient, 16 bits (held after the handshake)
//   R          remainder, 8 bits (held after the handshake)
//   dz         divide-by-zero flag for the current result
//
// Configuration:
//   APPROX_DIV_EN  when defined, only 16-TRUNC iterations run; Q carries the
//                  exact upper quotient bits left-aligned with the low TRUNC
//                  bits zero, and R is forced to 0. TRUNC must be 0..15.

module seq_div_16x8 #(
  parameter int unsigned TRUNC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Q,
  output logic [7:0]  R,
  output logic        dz
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

`ifdef APPROX_DIV_EN
  localparam int unsigned NUM_ITER = 16 - TRUNC;
`else
  localparam int unsigned NUM_ITER = 16;
`endif
  localparam logic [4:0] LAST_ITER = 5'(NUM_ITER - 1);

  if (TRUNC > 15) begin : g_trunc_range
    $error("seq_div_16x8: TRUNC must be in 0..15");
  end

  state_t      state_q, state_d;
  logic [7:0]  b_q, b_d;
  // Partial remainder. It is always < B after every step, so 8 bits hold
  // it; the extra bit needed during the compare lives only in trial below.
  logic [7:0]  p_q, p_d;
  logic [15:0] qsr_q, qsr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] q_q, q_d;
  logic [7:0]  r_q, r_d;
  logic        dz_q, dz_d;

  // One restoring step. trial is 9 bits wide so that shifting a partial
  // remainder with its MSB set does not wrap before the compare.
  logic [8:0]  trial;
  logic        take;
  logic [7:0]  p_iter;
  logic [15:0] qsr_iter;

  always_comb begin
    trial    = {p_q, qsr_q[15]};
    take     = (trial >= {1'b0, b_q});
    // When take is set the true difference is < B <= 255, so the low
    // 8 bits of the modulo-256 subtraction are the exact result.
    p_iter   = take ? (trial[7:0] - b_q) : trial[7:0];
    qsr_iter = {qsr_q[14:0], take};
  end

  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    p_d       = p_q;
    qsr_d     = qsr_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    r_d       = r_q;
    dz_d      = dz_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          b_d = B;
          if (B == 8'd0) begin
            q_d     = 16'hFFFF;
            r_d     = A[7:0];
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            p_d     = 8'd0;
            qsr_d   = A;
            cnt_d   = 5'd0;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        p_d   = p_iter;
        qsr_d = qsr_iter;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
`ifdef APPROX_DIV_EN
          // The low NUM_ITER bits of the shift register are the quotient
          // of A[15:TRUNC] / B; shifting by TRUNC left-aligns them and
          // discards the unconsumed dividend bits above them.
          q_d = qsr_iter << TRUNC;
          r_d = 8'd0;
`else
          q_d = qsr_iter;
          r_d = p_iter;
`endif
          dz_d    = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      b_q     <= 8'd0;
      p_q     <= 8'd0;
      qsr_q   <= 16'd0;
      cnt_q   <= 5'd0;
      q_q     <= 16'd0;
      r_q     <= 8'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      p_q     <= p_d;
      qsr_q   <= qsr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign Q  = q_q;
  assign R  = r_q;
  assign dz = dz_q;

endmodule

// File: tb/tb_seq_div_16x8.sv
// tb/tb_seq_div_16x8.sv - self-checking bench for seq_div_16x8

module tb_seq_div_16x8;

  localparam int unsigned TRUNC_P = 4;
`ifdef APPROX_DIV_EN
  localparam int CALC_LAT = 17 - int'(TRUNC_P);
`else
  localparam int CALC_LAT = 17;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = 16'd0;
  logic [7:0]  B = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        dz;

  int vectors = 0;
  int miscompares = 0;

  seq_div_16x8 #(.TRUNC(TRUNC_P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .R         (R),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  // Reference: plain integer division, truncated form when approximating.
  function automatic void ref_div(input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] q, output logic [7:0] r,
                                  output logic z, output int lat);
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) begin
      q = 16'hFFFF; r = a[7:0]; z = 1'b1; lat = 1;
    end else begin
`ifdef APPROX_DIV_EN
      q = 16'(((ai >> TRUNC_P) / bi) << TRUNC_P);
      r = 8'd0;
`else
      q = 16'(ai / bi);
      r = 8'(ai % bi);
`endif
      z = 1'b0; lat = CALC_LAT;
    end
  endfunction

  // Counts edges from the accept edge until out_valid is seen high.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 60);
  endtask

  // Starts at a negedge in IDLE, ends at a negedge back in IDLE.
  task automatic run_op(input string nm, input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] eq, input logic [7:0] er, input logic edz,
                        input int hold);
    int lat, wc, elat;
    elat = edz ? 1 : CALC_LAT;
    A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
    wc = 0;
    while (!in_ready && wc < 50) begin
      @(negedge clk);
      wc++;
    end
    if (!in_ready) begin
      chk({nm, "_accept"}, 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({nm, "_busy"}, 32'(in_ready), 32'd0);
    wait_valid(lat);
    chk({nm, "_lat"}, 32'(lat), 32'(elat));
    chk({nm, "_q"}, 32'(Q), 32'(eq));
    chk({nm, "_r"}, 32'(R), 32'(er));
    chk({nm, "_dz"}, 32'(dz), 32'(edz));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({nm, "_hold_q"}, 32'(Q), 32'(eq));
      chk({nm, "_hold_r"}, 32'(R), 32'(er));
      chk({nm, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_drop_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_idle_ready"}, 32'(in_ready), 32'd1);
    chk({nm, "_keep_q"}, 32'(Q), 32'(eq));
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          hold;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [15:0] eq, ra;
    logic [7:0]  er, rb;
    logic        ez;
    int          lat, seen;

    // Expected values are the exact-division results.
    tbl[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 0};
    tbl[1] = '{16'd65535, 8'd1,   16'hFFFF,  8'd0,   1'b0, 0};
    tbl[2] = '{16'd5,     8'd200, 16'd0,     8'd5,   1'b0, 1};
    tbl[3] = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0, 0};
    tbl[4] = '{16'd100,   8'd0,   16'hFFFF,  8'h64,  1'b1, 2};
    tbl[5] = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 10};
    tbl[6] = '{16'd0,     8'd5,   16'd0,     8'd0,   1'b0, 0};
    tbl[7] = '{16'd65535, 8'd128, 16'd511,   8'd127, 1'b0, 0};
    tbl[8] = '{16'd509,   8'd255, 16'd1,     8'd254, 1'b0, 0};
    tbl[9] = '{16'd510,   8'd255, 16'd2,     8'd0,   1'b0, 1};

    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_r", 32'(R), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      eq = tbl[i].q;
      er = tbl[i].r;
`ifdef APPROX_DIV_EN
      if (!tbl[i].z) begin
        eq = (eq >> TRUNC_P) << TRUNC_P;
        er = 8'd0;
      end
`endif
      run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, eq, er, tbl[i].z, tbl[i].hold);
    end

    // Reset in the middle of CALC: outputs drop at once, nothing emitted.
    A = 16'd1000; B = 8'd7; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_q", 32'(Q), 32'd0);
    chk("midrst_r", 32'(R), 32'd0);
    chk("midrst_dz", 32'(dz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("midrst_no_emit", 32'(seen), 32'd0);
    ref_div(16'd200, 8'd3, eq, er, ez, lat);
    run_op("after_rst", 16'd200, 8'd3, eq, er, ez, 0);

    // in_valid held across DONE: second op waits for the handshake.
    A = 16'd200; B = 8'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    A = 16'd1000; B = 8'd7;
    wait_valid(lat);
    ref_div(16'd200, 8'd3, eq, er, ez, lat);
    chk("b2b_first_q", 32'(Q), 32'(eq));
    repeat (3) begin
      @(negedge clk);
      chk("b2b_wait_ready", 32'(in_ready), 32'd0);
      chk("b2b_wait_q", 32'(Q), 32'(eq));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(lat);
    chk("b2b_second_lat", 32'(lat), 32'(CALC_LAT));
    ref_div(16'd1000, 8'd7, eq, er, ez, lat);
    chk("b2b_second_q", 32'(Q), 32'(eq));
    chk("b2b_second_r", 32'(R), 32'(er));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (i % 7 == 3) rb = 8'd1;
      ref_div(ra, rb, eq, er, ez, lat);
      run_op($sformatf("rnd%0d_%0d_%0d", i, ra, rb), ra, rb, eq, er, ez,
             int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
